axi_burst_split_master: RTL and testbench
=========================================

AXI_BURST_SPLIT_MASTER -- requirements
Module: axi_burst_split_master

Interface
REQ-001 Parameter ADDR_W, default 32: AXI address width.
REQ-002 Parameter DATA_W, default 64: data width; power of two, 32..1024.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per AXI burst, 1..256.
REQ-004 Parameter TOTAL_W, default 16: width of the cmd_beats field.
REQ-005 Clocking: one clock; reset is asynchronous and active-low; ports named clk and resetn.
REQ-006 Ports, given as name / direction / width / meaning:
- clk, in, 1: clock.
- resetn, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: command accepted while high with cmd_valid.
- cmd_op, in, 1: 0 = write, 1 = read.
- cmd_addr, in, ADDR_W: start byte address; the low log2(DATA_W/8) bits are ignored.
- cmd_beats, in, TOTAL_W: total beats minus 1.
- wdata_valid / wdata_ready, in / out, 1: user write-data handshake.
- wdata_data / wdata_strb, in, DATA_W / DATA_W/8: user write beat.
- rdata_valid / rdata_ready, out / in, 1: user read-data handshake.
- rdata_data, out, DATA_W: read beat.
- rdata_last, out, 1: final beat of the whole command.
- busy, out, 1: command in progress.
- done, out, 1: one-cycle completion pulse.
- done_resp, out, 2: worst response seen over the command.
- m_axi_aw*: awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awvalid, awready, awprot, awcache, awlock, awqos, awregion; standard AXI4 widths.
- m_axi_w*: wdata, wstrb, wvalid, wready, wlast.
- m_axi_b*: bresp, bvalid, bready.
- m_axi_ar*: same set as the AW channel.
- m_axi_r*: rdata, rresp, rvalid, rready, rlast.

Function
REQ-007 cmd_ready SHALL be high only in IDLE; on acceptance, op, aligned address and remaining beats (cmd_beats+1) SHALL be registered.
REQ-008 FSM states SHALL be IDLE, ADDR, WDATA, BRESP, RDATA and DONE.
- IDLE -> ADDR on accept.
- ADDR -> WDATA or RDATA on the address handshake.
- WDATA -> BRESP after the wlast handshake.
- BRESP or RDATA -> ADDR if beats remain, otherwise DONE.
- DONE -> IDLE after one cycle.
REQ-009 Each burst length SHALL be min(remaining, MAX_BURST, beats_to_4K), where beats_to_4K = (4096 - addr[11:0]) >> log2(DATA_W/8). No burst SHALL cross a 4 KB boundary.
REQ-010 awlen/arlen SHALL be burst-1. awsize/arsize SHALL be log2(DATA_W/8). awburst/arburst SHALL be 2'b01 (INCR).
REQ-011 The remaining prot/cache/lock/qos/region fields SHALL be constant 0, except cache, which SHALL be 4'b0011.
REQ-012 The address and length SHALL be stable while awvalid/arvalid is high. Valid SHALL be held until ready is seen.
REQ-013 After each burst, the address SHALL advance by burst*(DATA_W/8) and remaining SHALL decrease by burst.
REQ-014 Only one burst SHALL be outstanding; AW and AR SHALL never both be valid.
REQ-015 In WDATA, the write channel SHALL pass through combinationally:
- m_axi_wvalid = wdata_valid
- wdata_ready = m_axi_wready
- m_axi_wdata = wdata_data and m_axi_wstrb = wdata_strb
- m_axi_wlast high when the beat counter equals awlen.
REQ-016 Outside WDATA, m_axi_wvalid and wdata_ready SHALL be 0.
REQ-017 In BRESP, bready SHALL be 1. In RDATA, the read channel SHALL pass through combinationally:
- m_axi_rready = rdata_ready
- rdata_valid = m_axi_rvalid
- rdata_last = m_axi_rlast AND final burst.
REQ-018 done_resp SHALL equal the numerically largest bresp, or rresp on any beat, seen since accept. It SHALL be held until the next accept.
REQ-019 The done pulse SHALL occur in state DONE. busy SHALL be high in all states except IDLE.
REQ-020 Backpressure (wdata_valid low, rdata_ready low, or awready/arready low) SHALL stall without loss or duplication.
REQ-021 An m_axi_rlast mismatch with the internal beat count SHALL NOT alter sequencing; the internal count governs.

Reset
REQ-022 While resetn is low, the state SHALL be IDLE and all counters SHALL be 0, asynchronously.
REQ-023 During reset, every valid output, bready, rready, done and busy SHALL be 0, and done_resp SHALL be 0.
REQ-024 cmd_ready SHALL be 0 during reset and SHALL rise in the first clock after release.
REQ-025 Reset mid-burst SHALL abandon the command with no completion pulse.

Structure
REQ-026 Package abm_pkg SHALL hold:
- the state enum;
- AXI burst and response constants (OKAY, EXOKAY, SLVERR, DECERR);
- the 4 KB page constant.
REQ-027 A combinational sub-module, abm_burst_len_calc, SHALL compute burst length from addr, remaining and MAX_BURST.

Verification (DATA_W=64, MAX_BURST=16)
REQ-028 Write at 0x1000, cmd_beats=3 -> one AW with awaddr 0x1000 and awlen 3; wlast on beat 4; done with done_resp 0.
REQ-029 Read at 0x0FF0, cmd_beats=39 -> four AR bursts:
- araddr 0x0FF0, len 1
- araddr 0x1000, len 15
- araddr 0x1080, len 15
- araddr 0x1100, len 5
rdata_last SHALL occur only on beat 40.
REQ-030 Write at 0x0, cmd_beats=299 -> 19 AW bursts: 18 with len 15 and the last at 0x900 with len 11; exactly 300 W beats.
REQ-031 Three-burst write with bresp=2'b10 on burst 2 -> all three bursts complete; done_resp=2'b10.
REQ-032 Read with rdata_ready toggling every other cycle -> m_axi_rready mirrors it; all 16 beats are delivered in order.
REQ-033 resetn low on beat 5 of 16 of a write -> wvalid, awvalid and busy are 0 immediately; no done pulse; cmd_ready is 1 on the first clock after release.

Source files
------------

// File: rtl/abm_pkg.sv
// Shared types and AXI constants for the burst-splitting AXI4 master.
package abm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_BRESP = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } abm_state_e;

    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_EXOKAY = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [12:0] PAGE_BYTES  = 13'd4096;
    localparam logic [3:0]  AXI_CACHE   = 4'b0011;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/abm_burst_len_calc.sv
// Combinational burst sizing: min(remaining, MAX_BURST, beats left in the 4 KB page).
module abm_burst_len_calc
    import abm_pkg::*;
#(
    parameter int TOTAL_W   = 16,
    parameter int MAX_BURST = 16,
    parameter int SIZE_LOG2 = 3
) (
    input  logic [11:0]      i_page_off,
    input  logic [TOTAL_W:0] i_remaining,
    output logic [8:0]       o_burst
);

    localparam int              RW      = TOTAL_W + 1;
    localparam logic [RW-1:0]   MAX_REM = RW'(MAX_BURST);
    localparam logic [8:0]      MAX_B9  = 9'(MAX_BURST);

    logic [12:0] w_to_4k;
    logic [8:0]  w_cap;

    // Clip the remaining count to MAX_BURST, then to the page boundary.
    always_comb begin
        w_to_4k = (PAGE_BYTES - {1'b0, i_page_off}) >> SIZE_LOG2;
        if (i_remaining >= MAX_REM) begin
            w_cap = MAX_B9;
        end else begin
            w_cap = i_remaining[8:0];
        end
        if ({4'b0000, w_cap} <= w_to_4k) begin
            o_burst = w_cap;
        end else begin
            o_burst = w_to_4k[8:0];
        end
    end

endmodule

// File: rtl/axi_burst_split_master.sv
// AXI4 master that splits a user read/write command into INCR bursts, one outstanding at a time.
module axi_burst_split_master
    import abm_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 16,
    parameter int TOTAL_W   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [TOTAL_W-1:0]  cmd_beats,
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [DATA_W-1:0]   wdata_data,
    input  logic [DATA_W/8-1:0] wdata_strb,
    output logic                rdata_valid,
    input  logic                rdata_ready,
    output logic [DATA_W-1:0]   rdata_data,
    output logic                rdata_last,
    output logic                busy,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awcache,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awqos,
    output logic [3:0]          m_axi_awregion,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic                m_axi_wlast,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arcache,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arqos,
    output logic [3:0]          m_axi_arregion,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    input  logic                m_axi_rlast
);

    localparam int                SIZE_LOG2  = $clog2(DATA_W / 8);
    localparam int                RW         = TOTAL_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << SIZE_LOG2;

    abm_state_e        r_state;
    abm_state_e        w_next;
    logic              r_alive;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [RW-1:0]     r_remain;
    logic [7:0]        r_beat;
    logic [1:0]        r_resp;

    logic [8:0] w_burst;
    logic [7:0] w_len;
    logic       w_accept, w_addr_hs, w_w_hs, w_b_hs, w_r_hs;
    logic       w_beat_last, w_last_burst, w_burst_end;

    abm_burst_len_calc #(
        .TOTAL_W  (TOTAL_W),
        .MAX_BURST(MAX_BURST),
        .SIZE_LOG2(SIZE_LOG2)
    ) u_len (
        .i_page_off (r_addr[11:0]),
        .i_remaining(r_remain),
        .o_burst    (w_burst)
    );

    // A 256-beat burst wraps [7:0] to zero, so subtracting in 8 bits still yields 255.
    assign w_len        = w_burst[7:0] - 8'd1;
    assign w_beat_last  = (r_beat == w_len);
    assign w_last_burst = (r_remain == RW'(w_burst));
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_addr_hs    = (r_state == S_ADDR) && (r_op ? m_axi_arready : m_axi_awready);
    assign w_w_hs       = (r_state == S_WDATA) && wdata_valid && m_axi_wready;
    assign w_b_hs       = (r_state == S_BRESP) && m_axi_bvalid;
    assign w_r_hs       = (r_state == S_RDATA) && m_axi_rvalid && rdata_ready;
    assign w_burst_end  = w_b_hs || (w_r_hs && w_beat_last);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the internal beat count, not m_axi_rlast, ends a read burst.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ADDR; else w_next = S_IDLE;
            S_ADDR:  if (w_addr_hs) w_next = r_op ? S_RDATA : S_WDATA; else w_next = S_ADDR;
            S_WDATA: if (w_w_hs && w_beat_last) w_next = S_BRESP; else w_next = S_WDATA;
            S_BRESP: if (w_b_hs) w_next = w_last_burst ? S_DONE : S_ADDR; else w_next = S_BRESP;
            S_RDATA: if (w_burst_end) w_next = w_last_burst ? S_DONE : S_ADDR; else w_next = S_RDATA;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command context, per-burst beat counter and worst-response accumulator.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_alive  <= 1'b0;
            r_op     <= 1'b0;
            r_addr   <= '0;
            r_remain <= '0;
            r_beat   <= 8'd0;
            r_resp   <= RESP_OKAY;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_op     <= cmd_op;
                r_addr   <= cmd_addr & ALIGN_MASK;
                r_remain <= {1'b0, cmd_beats} + RW'(1);
                r_beat   <= 8'd0;
                r_resp   <= RESP_OKAY;
            end else begin
                if (w_w_hs || w_r_hs) begin
                    r_beat <= w_beat_last ? 8'd0 : r_beat + 8'd1;
                end
                if (w_b_hs || w_r_hs) begin
                    r_resp <= resp_max(r_resp, w_b_hs ? m_axi_bresp : m_axi_rresp);
                end
                if (w_burst_end) begin
                    r_addr   <= r_addr + (ADDR_W'(w_burst) << SIZE_LOG2);
                    r_remain <= r_remain - RW'(w_burst);
                end
            end
        end
    end

    assign cmd_ready = r_alive && (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign done_resp = r_resp;

    assign m_axi_awaddr   = r_addr;
    assign m_axi_awlen    = w_len;
    assign m_axi_awsize   = 3'(SIZE_LOG2);
    assign m_axi_awburst  = BURST_INCR;
    assign m_axi_awvalid  = (r_state == S_ADDR) && !r_op;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awcache  = AXI_CACHE;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awqos    = 4'b0000;
    assign m_axi_awregion = 4'b0000;

    assign m_axi_araddr   = r_addr;
    assign m_axi_arlen    = w_len;
    assign m_axi_arsize   = 3'(SIZE_LOG2);
    assign m_axi_arburst  = BURST_INCR;
    assign m_axi_arvalid  = (r_state == S_ADDR) && r_op;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arcache  = AXI_CACHE;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arqos    = 4'b0000;
    assign m_axi_arregion = 4'b0000;

    assign m_axi_wdata  = wdata_data;
    assign m_axi_wstrb  = wdata_strb;
    assign m_axi_wvalid = (r_state == S_WDATA) && wdata_valid;
    assign wdata_ready  = (r_state == S_WDATA) && m_axi_wready;
    assign m_axi_wlast  = (r_state == S_WDATA) && w_beat_last;
    assign m_axi_bready = (r_state == S_BRESP);

    assign m_axi_rready = (r_state == S_RDATA) && rdata_ready;
    assign rdata_valid  = (r_state == S_RDATA) && m_axi_rvalid;
    assign rdata_data   = m_axi_rdata;
    assign rdata_last   = (r_state == S_RDATA) && m_axi_rlast && w_last_burst;

endmodule

// File: tb/tb_axi_burst_split_master.sv
// Scoreboard bench: reference model fills expectation queues, a monitor pops them on DUT handshakes.
module tb_axi_burst_split_master;

    typedef struct { bit op; logic [31:0] addr; logic [7:0] len; } burst_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; bit last; } beat_t;

    logic        clk, resetn;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        wdata_valid, wdata_ready;
    logic [63:0] wdata_data;
    logic [7:0]  wdata_strb;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [63:0] rdata_data;
    logic        busy, done;
    logic [1:0]  done_resp;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_awregion, m_axi_arregion;
    logic        m_axi_awlock, m_axi_arlock;
    logic [63:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;

    axi_burst_split_master #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(16), .TOTAL_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata_data(wdata_data), .wdata_strb(wdata_strb),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .rdata_data(rdata_data), .rdata_last(rdata_last),
        .busy(busy), .done(done), .done_resp(done_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awprot(m_axi_awprot), .m_axi_awcache(m_axi_awcache), .m_axi_awlock(m_axi_awlock),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_wlast(m_axi_wlast),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast)
    );

    burst_t      exp_addr_q[$];
    beat_t       exp_w_q[$];
    beat_t       exp_r_q[$];
    logic [1:0]  exp_done_q[$];
    logic [31:0] obs_ar_addr[$];
    logic [7:0]  obs_ar_len[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          aw_cnt = 0, ar_cnt = 0, w_cnt = 0;
    int          b_issued = 0, r_bursts = 0;
    int          err_burst = -1;
    logic [1:0]  err_resp = 2'b00;
    logic [1:0]  last_resp = 2'b00;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] rd_fn(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: actual=expired required=finished");
        $fatal(1, "watchdog");
    end

    // Write-side slave: random AW/W ready, one B per completed burst.
    initial begin
        int wbeat; int b_pend; logic [7:0] wlen_q[$]; bit aw_hs, w_hs, b_hs;
        wbeat = 0; b_pend = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            if (!resetn) begin
                wlen_q.delete(); wbeat = 0; b_pend = 0;
            end else begin
                if (aw_hs) wlen_q.push_back(m_axi_awlen);
                if (w_hs && wlen_q.size() > 0) begin
                    if (wbeat == int'(wlen_q[0])) begin
                        void'(wlen_q.pop_front()); wbeat = 0; b_pend++;
                    end else wbeat++;
                end
            end
            @(posedge clk); #1;
            m_axi_awready = ($urandom_range(0, 3) != 0);
            m_axi_wready  = ($urandom_range(0, 3) != 0);
            if (!resetn) m_axi_bvalid = 1'b0;
            else begin
                if (b_hs) m_axi_bvalid = 1'b0;
                if (!m_axi_bvalid && b_pend > 0 && $urandom_range(0, 1) == 1) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (b_issued == err_burst) ? err_resp : 2'b00;
                    b_issued++; b_pend--;
                end
            end
        end
    end

    // Read-side slave: returns rd_fn(address) per beat, error response on first beat of the chosen burst.
    initial begin
        burst_t rq[$]; int rbeat; bit ar_hs, r_hs;
        rbeat = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 64'd0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (!resetn) begin
                rq.delete(); rbeat = 0;
            end else begin
                if (ar_hs) rq.push_back('{op: 1'b1, addr: m_axi_araddr, len: m_axi_arlen});
                if (r_hs && rq.size() > 0) begin
                    if (rbeat == int'(rq[0].len)) begin
                        void'(rq.pop_front()); rbeat = 0; r_bursts++;
                    end else rbeat++;
                end
            end
            @(posedge clk); #1;
            m_axi_arready = ($urandom_range(0, 3) != 0);
            if (!resetn) m_axi_rvalid = 1'b0;
            else if (r_hs || !m_axi_rvalid) begin
                if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = rd_fn(rq[0].addr + 32'(rbeat * 8));
                    m_axi_rlast  = (rbeat == int'(rq[0].len));
                    m_axi_rresp  = (r_bursts == err_burst && rbeat == 0) ? err_resp : 2'b00;
                end else m_axi_rvalid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a handshake or pulses done.
    initial begin
        bit prev_pend; logic [31:0] prev_addr, ma; logic [7:0] prev_len, ml;
        burst_t eb; beat_t ew; logic [1:0] er;
        prev_pend = 1'b0; prev_addr = 32'd0; prev_len = 8'd0;
        forever begin
            @(negedge clk);
            if (!resetn) prev_pend = 1'b0;
            else begin
                ma = m_axi_awvalid ? m_axi_awaddr : m_axi_araddr;
                ml = m_axi_awvalid ? m_axi_awlen  : m_axi_arlen;
                if (m_axi_awvalid || m_axi_arvalid)
                    cmp("aw_ar_both_valid", 64'(m_axi_awvalid & m_axi_arvalid), 64'd0);
                if (prev_pend) begin
                    cmp("addr_valid_held", 64'(m_axi_awvalid | m_axi_arvalid), 64'd1);
                    cmp("addr_len_stable", {24'd0, ma, ml}, {24'd0, prev_addr, prev_len});
                end
                prev_pend = (m_axi_awvalid && !m_axi_awready) || (m_axi_arvalid && !m_axi_arready);
                prev_addr = ma; prev_len = ml;
                if ((m_axi_awvalid && m_axi_awready) || (m_axi_arvalid && m_axi_arready)) begin
                    if (m_axi_awvalid) aw_cnt++;
                    else begin ar_cnt++; obs_ar_addr.push_back(ma); obs_ar_len.push_back(ml); end
                    if (m_axi_awvalid)
                        cmp("aw_fixed_fields", {m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot, m_axi_awlock, m_axi_awqos, m_axi_awregion},
                            {3'd3, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0});
                    else
                        cmp("ar_fixed_fields", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arlock, m_axi_arqos, m_axi_arregion},
                            {3'd3, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0});
                    if (exp_addr_q.size() == 0) cmp("addr_unexpected", 64'd1, 64'd0);
                    else begin
                        eb = exp_addr_q.pop_front();
                        cmp("burst_op", 64'(m_axi_arvalid), 64'(eb.op));
                        cmp("burst_addr", 64'(ma), 64'(eb.addr));
                        cmp("burst_len", 64'(ml), 64'(eb.len));
                    end
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    w_cnt++;
                    if (exp_w_q.size() == 0) cmp("w_unexpected", 64'd1, 64'd0);
                    else begin
                        ew = exp_w_q.pop_front();
                        cmp("w_data", m_axi_wdata, ew.data);
                        cmp("w_strb_last", {55'd0, m_axi_wstrb, m_axi_wlast}, {55'd0, ew.strb, ew.last});
                    end
                end
                if (m_axi_rvalid)
                    cmp("r_passthrough", {62'd0, m_axi_rready, rdata_valid}, {62'd0, rdata_ready, 1'b1});
                if (rdata_valid && rdata_ready) begin
                    if (exp_r_q.size() == 0) cmp("r_unexpected", 64'd1, 64'd0);
                    else begin
                        ew = exp_r_q.pop_front();
                        cmp("r_data", rdata_data, ew.data);
                        cmp("r_last", 64'(rdata_last), 64'(ew.last));
                    end
                end
                if (done) begin
                    if (exp_done_q.size() == 0) cmp("done_unexpected", 64'd1, 64'd0);
                    else begin
                        er = exp_done_q.pop_front();
                        cmp("done_resp", 64'(done_resp), 64'(er));
                    end
                end
            end
        end
    end

    // Issue one command; the model splits it by the 4 KB / MAX_BURST rules and fills the queues.
    task automatic run_cmd(input bit op, input logic [31:0] addr, input int beats,
                           input int err_k, input logic [1:0] eresp, input bit toggle, input int abort_at);
        logic [31:0] a; int rem, b, to4k, nb, wi, cyc; bit acc;
        logic [63:0] wd[$]; logic [7:0] ws[$]; logic [63:0] d; logic [7:0] s; logic [1:0] resp_exp;
        a = addr & ~32'h7; rem = beats; nb = 0;
        while (rem > 0) begin
            to4k = (4096 - int'(a % 32'd4096)) / 8;
            b = rem;
            if (b > 16) b = 16;
            if (b > to4k) b = to4k;
            exp_addr_q.push_back('{op: op, addr: a, len: 8'(b - 1)});
            for (int i = 0; i < b; i++) begin
                if (!op) begin
                    d = {$urandom, $urandom}; s = 8'($urandom);
                    wd.push_back(d); ws.push_back(s);
                    exp_w_q.push_back('{data: d, strb: s, last: (i == b - 1)});
                end else
                    exp_r_q.push_back('{data: rd_fn(a + 32'(i * 8)), strb: 8'd0, last: (rem == b && i == b - 1)});
            end
            a = a + 32'(b * 8); rem = rem - b; nb++;
        end
        resp_exp = (err_k < nb) ? eresp : 2'b00;
        if (abort_at < 0) exp_done_q.push_back(resp_exp);
        err_burst = (op ? r_bursts : b_issued) + err_k;
        err_resp = eresp;

        cmp("done_resp_held", 64'(done_resp), 64'(last_resp));
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_beats = 16'(beats - 1);
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmp("cmd_accepted", 64'(acc), 64'd1);

        wi = 0; cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            if (wdata_valid && wdata_ready) wi++;
            if (exp_done_q.size() == 0 && abort_at < 0) break;
            @(posedge clk); #1;
            if (abort_at >= 0 && wi == abort_at) begin
                resetn = 1'b0; #1;
                cmp("rst_outputs_low", {54'd0, m_axi_wvalid, m_axi_awvalid, busy, done, cmd_ready,
                                        m_axi_bready, m_axi_rready, m_axi_arvalid, rdata_valid, wdata_ready}, 64'd0);
                cmp("rst_done_resp", 64'(done_resp), 64'd0);
                exp_addr_q.delete(); exp_w_q.delete(); exp_r_q.delete();
                wdata_valid = 1'b0; err_burst = -1;
                repeat (3) @(posedge clk);
                @(negedge clk);
                cmp("rst_hold_cmd_ready", {62'd0, cmd_ready, busy}, 64'd0);
                @(posedge clk); #1; resetn = 1'b1;
                @(negedge clk);
                cmp("cmd_ready_before_clock", 64'(cmd_ready), 64'd0);
                @(negedge clk);
                cmp("cmd_ready_after_clock", 64'(cmd_ready), 64'd1);
                repeat (6) @(negedge clk);
                cmp("no_done_after_abort", 64'(busy), 64'd0);
                last_resp = 2'b00;
                return;
            end
            if (!op && wi < beats && $urandom_range(0, 3) != 0) begin
                wdata_valid = 1'b1; wdata_data = wd[wi]; wdata_strb = ws[wi];
            end else wdata_valid = 1'b0;
            rdata_ready = toggle ? ~rdata_ready : ($urandom_range(0, 3) != 0);
            cyc++;
        end
        wdata_valid = 1'b0;
        cmp("cmd_completed", 64'(exp_done_q.size()), 64'd0);
        cmp("queues_drained", 64'(exp_addr_q.size() + exp_w_q.size() + exp_r_q.size()), 64'd0);
        exp_done_q.delete();
        last_resp = resp_exp;
    endtask

    initial begin
        int a0, r0, w0;
        logic [31:0] ar_req_addr[4];
        logic [7:0]  ar_req_len[4];
        ar_req_addr = '{32'h0FF0, 32'h1000, 32'h1080, 32'h1100};
        ar_req_len  = '{8'd1, 8'd15, 8'd15, 8'd5};
        resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 32'd0; cmd_beats = 16'd0;
        wdata_valid = 1'b0; wdata_data = 64'd0; wdata_strb = 8'd0; rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_outputs", {53'd0, cmd_ready, busy, done, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid,
                              m_axi_bready, m_axi_rready, rdata_valid, wdata_ready, 1'b0}, 64'd0);
        cmp("reset_done_resp", 64'(done_resp), 64'd0);
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk);
        cmp("cmd_ready_pre_clock", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        cmp("cmd_ready_post_clock", 64'(cmd_ready), 64'd1);

        a0 = aw_cnt;
        run_cmd(1'b0, 32'h1000, 4, 99, 2'b00, 1'b0, -1);
        cmp("wr4_aw_count", 64'(aw_cnt - a0), 64'd1);

        r0 = ar_cnt; obs_ar_addr.delete(); obs_ar_len.delete();
        run_cmd(1'b1, 32'h0FF0, 40, 99, 2'b00, 1'b0, -1);
        cmp("rd40_ar_count", 64'(ar_cnt - r0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_ar_addr.size()) begin
                cmp("rd40_araddr", 64'(obs_ar_addr[i]), 64'(ar_req_addr[i]));
                cmp("rd40_arlen", 64'(obs_ar_len[i]), 64'(ar_req_len[i]));
            end
        end

        a0 = aw_cnt; w0 = w_cnt;
        run_cmd(1'b0, 32'h0000, 300, 99, 2'b00, 1'b0, -1);
        cmp("wr300_aw_count", 64'(aw_cnt - a0), 64'd19);
        cmp("wr300_w_count", 64'(w_cnt - w0), 64'd300);

        a0 = aw_cnt;
        run_cmd(1'b0, 32'h2000, 48, 1, 2'b10, 1'b0, -1);
        cmp("wr3_aw_count", 64'(aw_cnt - a0), 64'd3);
        cmp("wr3_done_resp", 64'(done_resp), 64'd2);

        run_cmd(1'b1, 32'h3000, 16, 99, 2'b00, 1'b1, -1);

        for (int n = 0; n < 24; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? {17'd0, 3'($urandom), 12'($urandom_range(12'hF00, 12'hFFF))}
                                             : 32'($urandom_range(0, 32'h7FFF));
            run_cmd(1'($urandom_range(0, 1)), ra, $urandom_range(1, 70), $urandom_range(0, 5),
                    2'($urandom_range(1, 3)), 1'b0, -1);
        end

        run_cmd(1'b0, 32'h4000, 16, 99, 2'b00, 1'b0, 4);
        run_cmd(1'b0, 32'h5000, 8, 0, 2'b11, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
